// File: rtl/piso_pkg.sv
// Shared types for the parallel-in/serial-out serializer: FSM state encoding
// and the even-parity helper used when PISO_PARITY_EN is defined.
package piso_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_e;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit counter for one frame: cleared when a word is loaded, advanced on each
// emitted data bit, and flags the last data bit. Saturates at WIDTH.
module piso_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load clears, enable advances, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i && (cnt_q != CNT_W'(WIDTH))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The bit emitted while the count reads WIDTH-1 is the last data bit.
    assign tc_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer feeding a downstream SIPO.
// Define PISO_PARITY_EN to append one even-parity bit after the data bits.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             bit_en,
    output logic             serial_out,
    output logic             shift_out,
    output logic             frame_done,
    output logic             busy
);

    piso_state_e      state_q;
    piso_state_e      state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic             serial_q;
    logic             serial_d;
    logic             shift_q;
    logic             shift_d;
    logic             done_q;
    logic             done_d;
`ifdef PISO_PARITY_EN
    logic             parity_q;
    logic             parity_d;
`endif

    logic             accept_s;
    logic             emit_data_s;
    logic             last_bit_s;
    logic             next_bit_s;
    logic [WIDTH-1:0] shifted_s;

    assign accept_s    = (state_q == IDLE) && in_valid;
    assign emit_data_s = (state_q == SHIFT) && bit_en;
    assign next_bit_s  = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];
    assign shifted_s   = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], 1'b0}
                                          : {1'b0, sreg_q[WIDTH-1:1]};

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .load_i (accept_s),
        .en_i   (emit_data_s),
        .tc_o   (last_bit_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bit_en && last_bit_s) begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
`endif
                end else begin
                    state_d = SHIFT;
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (bit_en) begin
                    state_d = IDLE;
                end else begin
                    state_d = PARITY;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs and datapath next values; strobes default low so each pulse is one cycle.
    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
        sreg_d   = sreg_q;
        serial_d = serial_q;
        shift_d  = 1'b0;
        done_d   = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sreg_d = in_data;
`ifdef PISO_PARITY_EN
                    parity_d = even_parity(32'(in_data));
`endif
                end else begin
                    sreg_d = sreg_q;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    serial_d = next_bit_s;
                    sreg_d   = shifted_s;
                    shift_d  = 1'b1;
`ifdef PISO_PARITY_EN
                    done_d   = 1'b0;
`else
                    done_d   = last_bit_s;
`endif
                end else begin
                    serial_d = serial_q;
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (bit_en) begin
                    serial_d = parity_q;
                    shift_d  = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    serial_d = serial_q;
                end
            end
`endif
            default: begin
                sreg_d = sreg_q;
            end
        endcase
    end

    // Datapath and registered output strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg_q   <= {WIDTH{1'b0}};
            serial_q <= 1'b0;
            shift_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            sreg_q   <= sreg_d;
            serial_q <= serial_d;
            shift_q  <= shift_d;
            done_q   <= done_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign serial_out = serial_q;
    assign shift_out  = shift_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: an MSB-first and an LSB-first serializer share stimulus;
// each output stream is reassembled by a modelled downstream SIPO.
module tb_piso_serializer;

    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             bit_en;
    logic             m_ready, m_ser, m_shift, m_done, m_busy;
    logic             l_ready, l_ser, l_shift, l_done, l_busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(m_ready), .bit_en(bit_en), .serial_out(m_ser),
        .shift_out(m_shift), .frame_done(m_done), .busy(m_busy)
    );

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(l_ready), .bit_en(bit_en), .serial_out(l_ser),
        .shift_out(l_shift), .frame_done(l_done), .busy(l_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one word, pulse bit_en once every 'period' cycles, and check the frame.
    task automatic run_frame(input logic [7:0] word, input int period, input string tag);
        logic [7:0] sipo_m = 8'h00;
        logic [7:0] sipo_l = 8'h00;
        int   n = 0, nl = 0, done_cnt = 0, done_at = -1;
        int   first_c = -1, last_c = -1, prev_c = 0;
        logic space_ok = 1'b1, stable_ok = 1'b1, busy_ok = 1'b1, done_ok = 1'b1;
        logic first_m = 1'b0, first_l = 1'b0, last_ser = 1'b0, par_bit = 1'b0;
        in_valid = 1'b1;
        in_data  = word;
        bit_en   = 1'b0;
        step();
        in_valid = 1'b0;
        in_data  = ~word;
        check_eq({tag, "_ready_after_accept"}, 32'(m_ready), 32'd0);
        for (int c = 0; c < 300 && n < FRAME_LEN; c++) begin
            bit_en = ((c % period) == 0);
            step();
            if (m_shift) begin
                if (n == 0) begin
                    first_c = c;
                    first_m = m_ser;
                end else if (c - prev_c != period) begin
                    space_ok = 1'b0;
                end
                prev_c = c;
                last_c = c;
                if (n < WIDTH) sipo_m = {sipo_m[6:0], m_ser};
                else par_bit = m_ser;
                last_ser = m_ser;
                n++;
            end else if (n > 0 && m_ser !== last_ser) begin
                stable_ok = 1'b0;
            end
            if (l_shift) begin
                if (nl == 0) first_l = l_ser;
                if (nl < WIDTH) sipo_l = {l_ser, sipo_l[7:1]};
                nl++;
            end
            if (m_done) begin
                done_cnt++;
                done_at = n;
                if (!m_shift) done_ok = 1'b0;
            end
            if (n < FRAME_LEN && !m_busy) busy_ok = 1'b0;
        end
        bit_en = 1'b0;
        check_eq({tag, "_strobes_msb"}, 32'(n), 32'(FRAME_LEN));
        check_eq({tag, "_strobes_lsb"}, 32'(nl), 32'(FRAME_LEN));
        check_eq({tag, "_first_edge"}, 32'(first_c), 32'd0);
        check_eq({tag, "_last_edge"}, 32'(last_c), 32'((FRAME_LEN - 1) * period));
        check_eq({tag, "_spacing"}, 32'(space_ok), 32'd1);
        check_eq({tag, "_serial_stable"}, 32'(stable_ok), 32'd1);
        check_eq({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
        check_eq({tag, "_done_with_strobe"}, 32'(done_ok), 32'd1);
        check_eq({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check_eq({tag, "_done_on_last"}, 32'(done_at), 32'(FRAME_LEN));
        check_eq({tag, "_first_bit_msb"}, 32'(first_m), 32'(word[7]));
        check_eq({tag, "_first_bit_lsb"}, 32'(first_l), 32'(word[0]));
        check_eq({tag, "_sipo_msb"}, 32'(sipo_m), 32'(word));
        check_eq({tag, "_sipo_lsb"}, 32'(sipo_l), 32'(word));
`ifdef PISO_PARITY_EN
        check_eq({tag, "_parity_bit"}, 32'(par_bit), 32'(^word));
`endif
        check_eq({tag, "_ready_after_frame"}, 32'(m_ready), 32'd1);
        check_eq({tag, "_idle_after_frame"}, 32'(m_busy), 32'd0);
        step();
        check_eq({tag, "_done_cleared"}, 32'(m_done), 32'd0);
        check_eq({tag, "_shift_cleared"}, 32'(m_shift), 32'd0);
    endtask

    initial begin
        int   n;
        int   strays;
        int   ready_gap;
        int   k;
        int   dones;
        logic [7:0] sipo;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        bit_en   = 1'b0;
        repeat (3) step();
        check_eq("rst_serial", 32'(m_ser), 32'd0);
        check_eq("rst_shift", 32'(m_shift), 32'd0);
        check_eq("rst_done", 32'(m_done), 32'd0);
        check_eq("rst_busy", 32'(m_busy), 32'd0);
        reset = 1'b0;
        check_eq("rst_ready_after_release", 32'(m_ready), 32'd1);
        step();

        run_frame(8'hA5, 1, "a5");
        run_frame(8'h01, 1, "x01");
        run_frame(8'h3C, 3, "x3c");
        run_frame(8'h07, 1, "x07");

        // Reset after the third bit of 0xFF aborts the frame.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        step();
        in_valid = 1'b0;
        bit_en   = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            step();
            if (m_shift) n++;
        end
        check_eq("abort_bits_before_reset", 32'(n), 32'd3);
        reset = 1'b1;
        #1;
        check_eq("abort_serial", 32'(m_ser), 32'd0);
        check_eq("abort_shift", 32'(m_shift), 32'd0);
        check_eq("abort_done", 32'(m_done), 32'd0);
        check_eq("abort_busy", 32'(m_busy), 32'd0);
        step();
        reset = 1'b0;
        check_eq("abort_ready_after_release", 32'(m_ready), 32'd1);
        strays = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (m_shift || m_done) strays++;
        end
        check_eq("abort_no_further_strobes", 32'(strays), 32'd0);
        bit_en = 1'b0;
        step();

        // Back-to-back words with in_valid held high.
        in_valid  = 1'b1;
        in_data   = 8'h11;
        bit_en    = 1'b1;
        ready_gap = 0;
        k         = 0;
        dones     = 0;
        sipo      = 8'h00;
        for (int c = 0; c < 2 * FRAME_LEN + 4; c++) begin
            step();
            if (m_shift) begin
                if (k < WIDTH) sipo = {sipo[6:0], m_ser};
                k++;
            end
            if (m_done) begin
                k = 0;
                dones++;
            end
            if (c >= 1 && c <= 2 * FRAME_LEN && m_ready) ready_gap++;
            if (c == FRAME_LEN) check_eq("b2b_frame1", 32'(sipo), 32'h11);
            if (c == 2 * FRAME_LEN + 1) check_eq("b2b_frame2", 32'(sipo), 32'h22);
            if (c == 0) in_data = 8'h99;
            if (c == 4) in_data = 8'h22;
            if (c == FRAME_LEN + 1) begin
                in_valid = 1'b0;
                in_data  = 8'h5A;
            end
        end
        bit_en = 1'b0;
        check_eq("b2b_ready_gap", 32'(ready_gap), 32'd1);
        check_eq("b2b_done_count", 32'(dones), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
